// File: rtl/sad_result_collector_pkg.sv
// Shared types and defaults for the SAD result collector.
package sad_result_collector_pkg;

    localparam int unsigned NUM_CORES_DEF = 8;
    localparam int unsigned DW_DEF        = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_REDUCE,
        ST_DONE
    } state_t;

    // One captured core result; field width is the default word width,
    // narrower DW values are zero-extended into it.
    typedef struct packed {
        logic [DW_DEF-1:0] x;
        logic [DW_DEF-1:0] y;
        logic [DW_DEF-1:0] sad;
    } result_t;

endpackage

// File: rtl/sad_min_compare.sv
// Combinational running-minimum step: keeps the best so far or takes the candidate.
module sad_min_compare
    import sad_result_collector_pkg::*;
#(
    parameter int IW = 3
)(
    input  result_t         best,
    input  logic [IW-1:0]   best_idx,
    input  result_t         cand,
    input  logic [IW-1:0]   cand_idx,
    input  logic            first,
    output result_t         sel,
    output logic [IW-1:0]   sel_idx,
    output logic            replace
);

    // Strict less-than keeps ties on the lower index; the first slot always
    // loads so an all-ones SAD still yields core 0's coordinates.
    always_comb begin
        replace = first | (cand.sad < best.sad);
        sel     = best;
        sel_idx = best_idx;
        if (replace) begin
            sel     = cand;
            sel_idx = cand_idx;
        end
    end

endmodule

// File: rtl/sad_result_collector.sv
// Collects one result per search core, then scans for the minimum SAD.
module sad_result_collector
    import sad_result_collector_pkg::*;
#(
    parameter int NUM_CORES = NUM_CORES_DEF,
    parameter int DW        = DW_DEF
)(
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        Start,
    input  logic [NUM_CORES-1:0]        CoreValid,
    input  logic [NUM_CORES*DW-1:0]     CoreX,
    input  logic [NUM_CORES*DW-1:0]     CoreY,
    input  logic [NUM_CORES*DW-1:0]     CoreSAD,
    output logic [NUM_CORES-1:0]        CoreAck,
    output logic [DW-1:0]               X,
    output logic [DW-1:0]               Y,
    output logic [DW-1:0]               SAD,
    output logic [((NUM_CORES > 1) ? $clog2(NUM_CORES) : 1)-1:0] BestCore,
    output logic                        Busy,
    output logic                        Done
);

    localparam int unsigned IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    state_t                 state;
    logic [NUM_CORES-1:0]   captured;
    result_t                slots [NUM_CORES];
    logic [IW-1:0]          scan_idx;
    result_t                best;
    logic [IW-1:0]          best_idx;

    result_t                sel;
    logic [IW-1:0]          sel_idx;
    logic                   replace;

    sad_min_compare #(
        .IW (IW)
    ) u_cmp (
        .best     (best),
        .best_idx (best_idx),
        .cand     (slots[scan_idx]),
        .cand_idx (scan_idx),
        .first    (scan_idx == '0),
        .sel      (sel),
        .sel_idx  (sel_idx),
        .replace  (replace)
    );

    // Result slot storage: first valid per slot in COLLECT wins, later data ignored.
    always_ff @(posedge Clk) begin
        if (!Reset && state == ST_COLLECT) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (CoreValid[i] && !captured[i]) begin
                    slots[i].x   <= DW_DEF'(CoreX[i*DW +: DW]);
                    slots[i].y   <= DW_DEF'(CoreY[i*DW +: DW]);
                    slots[i].sad <= DW_DEF'(CoreSAD[i*DW +: DW]);
                end
            end
        end
    end

    // Control FSM with capture flags, acks, reduction scan and published result.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= ST_IDLE;
            captured <= '0;
            CoreAck  <= '0;
            scan_idx <= '0;
            best     <= '{x: '0, y: '0, sad: '1};
            best_idx <= '0;
            X        <= '0;
            Y        <= '0;
            SAD      <= '0;
            BestCore <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
        end else begin
            CoreAck <= '0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (Start) begin
                        captured <= '0;
                        state    <= ST_COLLECT;
                        Busy     <= 1'b1;
                        Done     <= 1'b0;
                    end
                end
                ST_COLLECT: begin
                    for (int i = 0; i < NUM_CORES; i++) begin
                        if (CoreValid[i] && !captured[i]) begin
                            captured[i] <= 1'b1;
                            CoreAck[i]  <= 1'b1;
                        end
                    end
                    if (&captured) begin
                        state    <= ST_REDUCE;
                        scan_idx <= '0;
                        best     <= '{x: '0, y: '0, sad: '1};
                        best_idx <= '0;
                    end
                end
                ST_REDUCE: begin
                    if (replace) begin
                        best     <= sel;
                        best_idx <= sel_idx;
                    end
                    scan_idx <= scan_idx + IW'(1);
                    if (scan_idx == IW'(NUM_CORES - 1)) begin
                        state    <= ST_DONE;
                        Busy     <= 1'b0;
                        Done     <= 1'b1;
                        X        <= DW'(sel.x);
                        Y        <= DW'(sel.y);
                        SAD      <= DW'(sel.sad);
                        BestCore <= sel_idx;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sad_result_collector.sv
// Randomized directed bench for sad_result_collector with a behavioural reference.
module tb_sad_result_collector;

    localparam int N  = 8;
    localparam int DW = 32;

    logic            Clk = 1'b0;
    logic            Reset;
    logic            Start;
    logic [N-1:0]    CoreValid;
    logic [N*DW-1:0] CoreX, CoreY, CoreSAD;
    logic [N-1:0]    CoreAck;
    logic [DW-1:0]   X, Y, SAD;
    logic [2:0]      BestCore;
    logic            Busy, Done;

    sad_result_collector #(.NUM_CORES(N), .DW(DW)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .CoreValid (CoreValid),
        .CoreX     (CoreX),
        .CoreY     (CoreY),
        .CoreSAD   (CoreSAD),
        .CoreAck   (CoreAck),
        .X         (X),
        .Y         (Y),
        .SAD       (SAD),
        .BestCore  (BestCore),
        .Busy      (Busy),
        .Done      (Done)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // Per-round core behaviour: result values, first-valid cycle, extra hold cycles.
    logic [DW-1:0] rx [N];
    logic [DW-1:0] ry [N];
    logic [DW-1:0] rs [N];
    int            rel  [N];
    int            hold [N];

    // Core-side handshake state within a round.
    logic [N-1:0]  seen;
    int            extra [N];
    int            cyc;

    // Last published result.
    logic [DW-1:0] px, py, ps;
    logic [2:0]    pb;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic check_held(input string tag);
        check({tag, "_x_held"},    64'(X),        64'(px));
        check({tag, "_y_held"},    64'(Y),        64'(py));
        check({tag, "_sad_held"},  64'(SAD),      64'(ps));
        check({tag, "_best_held"}, 64'(BestCore), 64'(pb));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ack0"},  64'(CoreAck),  64'(0));
        check({tag, "_x0"},    64'(X),        64'(0));
        check({tag, "_y0"},    64'(Y),        64'(0));
        check({tag, "_sad0"},  64'(SAD),      64'(0));
        check({tag, "_best0"}, 64'(BestCore), 64'(0));
        check({tag, "_busy0"}, 64'(Busy),     64'(0));
        check({tag, "_done0"}, 64'(Done),     64'(0));
    endtask

    // A core raises valid from its release cycle until it sees ack, plus optional hold.
    task automatic next_valid(output logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (!seen[i]) begin
                v[i] = (cyc >= rel[i]);
            end else if (extra[i] > 0) begin
                v[i] = 1'b1;
                extra[i]--;
            end else begin
                v[i] = 1'b0;
            end
        end
    endtask

    // Present true data until the core's slot is taken, junk (SAD 0) afterwards.
    task automatic drive_cores(input logic [N-1:0] v, input logic [N-1:0] cap);
        CoreValid = v;
        for (int i = 0; i < N; i++) begin
            if (cap[i]) begin
                CoreX[i*DW +: DW]   = $urandom;
                CoreY[i*DW +: DW]   = $urandom;
                CoreSAD[i*DW +: DW] = '0;
            end else begin
                CoreX[i*DW +: DW]   = rx[i];
                CoreY[i*DW +: DW]   = ry[i];
                CoreSAD[i*DW +: DW] = rs[i];
            end
        end
    endtask

    task automatic note_acks();
        for (int i = 0; i < N; i++) begin
            if (CoreAck[i] && !seen[i]) begin
                seen[i]  = 1'b1;
                extra[i] = hold[i];
            end
        end
    endtask

    task automatic defaults_random(input int sad_max, input int rel_max, input int hold_max);
        for (int i = 0; i < N; i++) begin
            rx[i]   = $urandom;
            ry[i]   = $urandom;
            rs[i]   = DW'($urandom_range(sad_max, 0));
            rel[i]  = $urandom_range(rel_max, 0);
            hold[i] = $urandom_range(hold_max, 0);
        end
    endtask

    // One full round; reset_at > 0 asserts Reset on that post-capture cycle.
    task automatic run_round(input string name, input int reset_at);
        logic [N-1:0]  cap, v, eack;
        logic [DW-1:0] minv;
        int            widx;

        // Reference: smallest SAD, lowest index among equals.
        minv = '1;
        for (int i = 0; i < N; i++) if (rs[i] < minv) minv = rs[i];
        widx = -1;
        for (int i = 0; i < N; i++) if (widx < 0 && rs[i] == minv) widx = i;

        Start = 1'b1;
        drive_cores('0, '0);
        step();
        Start = 1'b0;
        check({name, "_busy_start"}, 64'(Busy), 64'(1));
        check({name, "_done_start"}, 64'(Done), 64'(0));
        check_held({name, "_start"});

        cap = '0; seen = '0; cyc = 0;
        for (int i = 0; i < N; i++) extra[i] = 0;
        while (cap != '1 && cyc < 100) begin
            next_valid(v);
            drive_cores(v, cap);
            step();
            eack = v & ~cap;
            check({name, "_ack"}, 64'(CoreAck), 64'(eack));
            cap |= v;
            note_acks();
            if (cap != '1) begin
                check({name, "_busy_col"}, 64'(Busy), 64'(1));
                check({name, "_done_col"}, 64'(Done), 64'(0));
            end
            cyc++;
        end
        check({name, "_all_captured"}, 64'(cap), 64'({N{1'b1}}));

        for (int k = 1; k <= N + 1; k++) begin
            next_valid(v);
            drive_cores(v, cap);
            cyc++;
            if (k == reset_at) Reset = 1'b1;
            step();
            if (k == reset_at) begin
                Reset = 1'b0;
                check_zero({name, "_rst"});
                px = '0; py = '0; ps = '0; pb = '0;
                drive_cores('0, '0);
                step();
                check({name, "_idle_busy"}, 64'(Busy), 64'(0));
                check({name, "_idle_done"}, 64'(Done), 64'(0));
                return;
            end
            check({name, "_noack_red"}, 64'(CoreAck), 64'(0));
            if (k < N + 1) begin
                check({name, "_busy_red"}, 64'(Busy), 64'(1));
                check({name, "_done_red"}, 64'(Done), 64'(0));
                check_held({name, "_red"});
            end else begin
                check({name, "_done"},  64'(Done),     64'(1));
                check({name, "_busy"},  64'(Busy),     64'(0));
                check({name, "_x"},     64'(X),        64'(rx[widx]));
                check({name, "_y"},     64'(Y),        64'(ry[widx]));
                check({name, "_sad"},   64'(SAD),      64'(rs[widx]));
                check({name, "_best"},  64'(BestCore), 64'(widx));
                px = rx[widx]; py = ry[widx]; ps = rs[widx]; pb = 3'(widx);
            end
        end
        drive_cores('0, '0);
    endtask

    initial begin
        Reset = 1'b1;
        Start = 1'b0;
        CoreValid = '0;
        CoreX = '0; CoreY = '0; CoreSAD = '0;
        px = '0; py = '0; ps = '0; pb = '0;
        step();
        step();
        check_zero("reset");
        Reset = 1'b0;

        // Valids while idle must not be acknowledged.
        CoreValid = '1;
        step();
        check("idle_noack", 64'(CoreAck), 64'(0));
        check("idle_busy",  64'(Busy),    64'(0));
        CoreValid = '0;
        step();

        // All cores on one cycle, SAD = i*10+5.
        defaults_random(0, 0, 0);
        for (int i = 0; i < N; i++) rs[i] = DW'(i * 10 + 5);
        run_round("s1_burst", -1);

        // Staggered, core 6 last with the smallest SAD.
        defaults_random(0, 0, 0);
        for (int i = 0; i < N; i++) begin
            rs[i]  = 100;
            rel[i] = i;
        end
        rs[6]  = 3;
        rel[6] = 12;
        run_round("s2_stagger", -1);

        // Tie between cores 2 and 5.
        defaults_random(0, 5, 0);
        for (int i = 0; i < N; i++) rs[i] = 50;
        rs[2] = 7;
        rs[5] = 7;
        run_round("s3_tie", -1);

        // Core 3 keeps valid for 4 cycles after capture, presenting junk.
        defaults_random(1000, 0, 0);
        for (int i = 0; i < N; i++) begin
            rs[i]  = rs[i] + 2;
            rel[i] = 2 + $urandom_range(4, 0);
        end
        rs[3]   = 1;
        rel[3]  = 0;
        hold[3] = 4;
        run_round("s4_hold", -1);

        // Reset in the middle of the scan, then a clean round.
        defaults_random(200, 4, 1);
        run_round("s5_rst", 4);
        defaults_random(200, 4, 1);
        run_round("s5_after", -1);

        // Every core reports all-ones.
        defaults_random(0, 3, 0);
        for (int i = 0; i < N; i++) rs[i] = '1;
        run_round("s6_ones", -1);

        // Random rounds with a narrow SAD range to force ties.
        for (int r = 0; r < 4; r++) begin
            defaults_random(15, 6, 2);
            run_round("s7_rand", -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sad_result_collector.md
SAD_RESULT_COLLECTOR -- requirements
Module: sad_result_collector

Interface
REQ-001 The module SHALL have parameter NUM_CORES, default 8, giving the number of search cores feeding the collector.
REQ-002 The module SHALL have parameter DW, default 32, giving the width of each X, Y and SAD word.
REQ-003 The module SHALL have port Clk, input, 1 bit: the single clock; all state changes on rising edge.
REQ-004 The module SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port Start, input, 1 bit: one-cycle pulse that begins a collection round.
REQ-006 The module SHALL have port CoreValid, input, NUM_CORES bits: bit i high means core i presents a result.
REQ-007 The module SHALL have port CoreX, input, NUM_CORES*DW bits: core i X at bits [i*DW +: DW].
REQ-008 The module SHALL have port CoreY, input, NUM_CORES*DW bits: core i Y, packed as CoreX.
REQ-009 The module SHALL have port CoreSAD, input, NUM_CORES*DW bits: core i SAD (unsigned), packed as CoreX.
REQ-010 The module SHALL have port CoreAck, output, NUM_CORES bits: one-cycle pulse on bit i acknowledging capture of core i.
REQ-011 The module SHALL have port X, output, DW bits: X of the winning result.
REQ-012 The module SHALL have port Y, output, DW bits: Y of the winning result.
REQ-013 The module SHALL have port SAD, output, DW bits: minimum SAD over all cores.
REQ-014 The module SHALL have port BestCore, output, clog2(NUM_CORES) bits: index of the winning core.
REQ-015 The module SHALL have port Busy, output, 1 bit: high in COLLECT and REDUCE.
REQ-016 The module SHALL have port Done, output, 1 bit: high in DONE.

Function
REQ-017 The FSM SHALL have states IDLE, COLLECT, REDUCE and DONE.
REQ-018 In IDLE or DONE, a Start pulse SHALL clear all captured flags and move the FSM to COLLECT on the next edge.
REQ-019 In COLLECT or REDUCE, Start SHALL be ignored.
REQ-020 In COLLECT, on each edge where CoreValid[i]=1 and slot i is not captured, the collector SHALL store core i's X/Y/SAD and set captured[i].
REQ-021 CoreAck[i] SHALL be high for exactly the cycle after that capture edge.
REQ-022 Multiple cores valid on the same edge SHALL all be captured on that edge.
REQ-023 CoreValid[i] on an already-captured slot, or outside COLLECT, SHALL be ignored and SHALL produce no ack.
REQ-024 Cores hold CoreValid until they see CoreAck.
REQ-025 On the edge after all captured flags are 1, the FSM SHALL enter REDUCE with scan index 0 and running minimum at all-ones.
REQ-026 REDUCE SHALL examine one slot per cycle in index order 0..NUM_CORES-1.
REQ-027 A slot SHALL replace the running best only when its SAD is strictly less than the running best, so ties resolve to the lowest index.
REQ-028 The edge that examines slot NUM_CORES-1 SHALL enter DONE and load X, Y, SAD and BestCore from the final best.
REQ-029 Done SHALL rise exactly NUM_CORES+1 cycles after the final capture edge.
REQ-030 X, Y, SAD and BestCore SHALL change only on entry to DONE and SHALL hold their values through later rounds until the next DONE.
REQ-031 A SAD of all-ones SHALL be a legal value; if every core reports it, core 0 wins.

Reset
REQ-032 Reset SHALL take priority over all other inputs, including mid-COLLECT and mid-REDUCE.
REQ-033 On Reset the FSM SHALL go to IDLE and all captured flags SHALL be cleared.
REQ-034 On Reset CoreAck, X, Y, SAD, BestCore, Busy and Done SHALL all be 0.
REQ-035 Reset SHALL discard any partially captured results.

Structure
REQ-036 A shared package SHALL hold the state enum, NUM_CORES/DW defaults, and the {x, y, sad} result struct.
REQ-037 One sub-module, sad_min_compare, SHALL implement the combinational compare: running best and candidate in, selected best and replace flag out.
REQ-038 The result slots SHALL be a register array inside sad_result_collector.

Verification
REQ-039 Scenario: Start, then all 8 valid on one cycle with SAD i*10+5 -> all CoreAck bits pulse together; Done 9 cycles later; SAD=5, BestCore=0.
REQ-040 Scenario: staggered valids, core 6 last, SAD6=3 and others 100 -> ack per core one cycle after its capture; Done 9 cycles after core 6 capture; BestCore=6, X/Y equal core 6 values.
REQ-041 Scenario: cores 2 and 5 both SAD=7, others 50 -> BestCore=2.
REQ-042 Scenario: core 3 holds valid for 4 cycles after capture -> exactly one ack, and its slot is not overwritten.
REQ-043 Scenario: Reset asserted during REDUCE -> next cycle all outputs 0 and state IDLE; a new round then completes normally.
REQ-044 Scenario: second round with Start from DONE -> previous X/Y/SAD held with Done=0 and Busy=1 until the new DONE.
